// File: rtl/yuv_mb_reorder.sv
// -----------------------------------------------------------------------------
// yuv_mb_reorder
//   Raster-to-macroblock reorder buffer for YUV420 video. A strip (one
//   macroblock row) arrives as a raster byte stream: 16 Y lines, then 8 U
//   lines, then 8 V lines. Two strip banks are used ping-pong so one strip can
//   be written while the previous one is read. Each 16x16 macroblock is
//   emitted as packed words, Y first, then U, then V. The first byte of a word
//   is placed in the MSBs.
//
//   Parameters
//     IMG_W      frame width in pixels, multiple of 16
//     IMG_H      frame height in pixels, multiple of 16
//     OUT_BYTES  bytes per output word: 1, 2, 4 or 8
//
//   Ports
//     clk         clock
//     rst_n       asynchronous active-low reset
//     data_in     input pixel byte
//     data_en     data_in valid this cycle
//     w_ready     write bank has room
//     r_ready     consumer accepts data_o this cycle
//     data_flag   data_o valid
//     data_o      packed output word
//     mb_last     data_o is the last word of a macroblock
//     frame_last  data_o is the last word of the frame
//     ovf         sticky: a byte arrived while the write bank was full
//
//   Build option
//     LUMA_ONLY_EN  when defined, only the Y part of each macroblock is
//                   emitted; chroma is still written so strip framing holds.
// -----------------------------------------------------------------------------
module yuv_mb_reorder #(
    parameter int IMG_W     = 1280,
    parameter int IMG_H     = 720,
    parameter int OUT_BYTES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             data_in,
    input  logic                   data_en,
    output logic                   w_ready,
    input  logic                   r_ready,
    output logic                   data_flag,
    output logic [8*OUT_BYTES-1:0] data_o,
    output logic                   mb_last,
    output logic                   frame_last,
    output logic                   ovf
);

    localparam int STRIP  = IMG_W * 24;
    localparam int NMB    = IMG_W / 16;
    localparam int NSTRIP = IMG_H / 16;
    localparam int OW     = 8 * OUT_BYTES;
    localparam int OB_SH  = $clog2(OUT_BYTES);
`ifdef LUMA_ONLY_EN
    localparam int WPM    = 256 / OUT_BYTES;
`else
    localparam int WPM    = 384 / OUT_BYTES;
`endif
    localparam int AW     = $clog2(2 * STRIP);
    localparam int CW     = $clog2(STRIP);
    localparam int WW     = $clog2(WPM);
    localparam int MBW    = (NMB > 1) ? $clog2(NMB) : 1;
    localparam int STW    = (NSTRIP > 1) ? $clog2(NSTRIP) : 1;

    // Strip storage: bank b occupies [b*STRIP, b*STRIP+STRIP-1]
    logic [7:0]    mem_q [0:2*STRIP-1];

    // Bank occupancy and write side
    logic [1:0]    full_q, full_d;
    logic          wr_bank_q, wr_bank_d;
    logic [CW-1:0] wr_cnt_q, wr_cnt_d;
    logic          wr_en_s, wr_fill_s;
    logic [AW-1:0] wr_addr_s;
    logic          w_ready_q, w_ready_d;
    logic          ovf_q;

    // Read address generator
    logic          rd_bank_q, rd_bank_d;
    logic [WW-1:0] rd_word_q, rd_word_d;
    logic [MBW-1:0] rd_mb_q, rd_mb_d;
    logic [STW-1:0] rd_strip_q, rd_strip_d;
    logic          rd_mb_last_s, rd_strip_last_s, rd_frame_last_s;
    logic [31:0]   off_s, strip_addr_s;
    logic [AW-1:0] rd_addr_s;
    logic          issue_s, out_adv_s, release_s;

    // Memory-read stage
    logic          mem_vld_q, mem_mb_last_q, mem_strip_last_q, mem_frame_last_q, mem_bank_q;
    logic [OW-1:0] mem_data_q;

    // Output register stage
    logic          data_flag_q, mb_last_q, frame_last_q, out_strip_last_q, out_bank_q;
    logic [OW-1:0] data_q;

    assign w_ready    = w_ready_q;
    assign data_flag  = data_flag_q;
    assign data_o     = data_q;
    assign mb_last    = mb_last_q;
    assign frame_last = frame_last_q;
    assign ovf        = ovf_q;

    // Write-side control: accept while the target bank is not full
    always_comb begin
        wr_en_s   = data_en & ~full_q[wr_bank_q];
        wr_fill_s = wr_en_s & (wr_cnt_q == CW'(STRIP - 1));
        wr_addr_s = AW'(32'(wr_cnt_q) + (wr_bank_q ? 32'(STRIP) : 32'd0));
        if (wr_fill_s) begin
            wr_cnt_d  = {CW{1'b0}};
            wr_bank_d = ~wr_bank_q;
        end else if (wr_en_s) begin
            wr_cnt_d  = wr_cnt_q + {{(CW-1){1'b0}}, 1'b1};
            wr_bank_d = wr_bank_q;
        end else begin
            wr_cnt_d  = wr_cnt_q;
            wr_bank_d = wr_bank_q;
        end
    end

    // Transfer handshake, prefetch issue and bank release
    always_comb begin
        out_adv_s = ~data_flag_q | r_ready;
        // A read may be issued whenever the memory-read stage will be free
        issue_s   = full_q[rd_bank_q] & (~mem_vld_q | out_adv_s);
        release_s = data_flag_q & r_ready & out_strip_last_q;
    end

    // Bank occupancy: release and fill of different banks may coincide
    always_comb begin
        full_d[0] = (full_q[0] & ~(release_s & ~out_bank_q)) | (wr_fill_s & ~wr_bank_q);
        full_d[1] = (full_q[1] & ~(release_s &  out_bank_q)) | (wr_fill_s &  wr_bank_q);
        w_ready_d = ~full_d[wr_bank_d];
    end

    // Macroblock address: Y rows of 16 bytes, then U and V rows of 8 bytes
    always_comb begin
        off_s = 32'(rd_word_q) << OB_SH;
        if (off_s < 32'd256) begin
            strip_addr_s = (off_s >> 4) * 32'(IMG_W) + 32'(rd_mb_q) * 32'd16 + (off_s & 32'd15);
        end else if (off_s < 32'd320) begin
            strip_addr_s = 32'd16 * 32'(IMG_W) + ((off_s - 32'd256) >> 3) * 32'(IMG_W / 2)
                         + 32'(rd_mb_q) * 32'd8 + (off_s & 32'd7);
        end else begin
            strip_addr_s = 32'd20 * 32'(IMG_W) + ((off_s - 32'd320) >> 3) * 32'(IMG_W / 2)
                         + 32'(rd_mb_q) * 32'd8 + (off_s & 32'd7);
        end
        rd_addr_s = AW'(strip_addr_s + (rd_bank_q ? 32'(STRIP) : 32'd0));
    end

    // Read counters: word within MB, MB within strip, strip within frame
    always_comb begin
        rd_mb_last_s    = (rd_word_q == WW'(WPM - 1));
        rd_strip_last_s = rd_mb_last_s & (rd_mb_q == MBW'(NMB - 1));
        rd_frame_last_s = rd_strip_last_s & (rd_strip_q == STW'(NSTRIP - 1));
        rd_word_d  = rd_word_q;
        rd_mb_d    = rd_mb_q;
        rd_strip_d = rd_strip_q;
        rd_bank_d  = rd_bank_q;
        if (issue_s) begin
            if (rd_strip_last_s) begin
                rd_word_d  = {WW{1'b0}};
                rd_mb_d    = {MBW{1'b0}};
                rd_bank_d  = ~rd_bank_q;
                rd_strip_d = rd_frame_last_s ? {STW{1'b0}} : rd_strip_q + {{(STW-1){1'b0}}, 1'b1};
            end else if (rd_mb_last_s) begin
                rd_word_d  = {WW{1'b0}};
                rd_mb_d    = rd_mb_q + {{(MBW-1){1'b0}}, 1'b1};
            end else begin
                rd_word_d  = rd_word_q + {{(WW-1){1'b0}}, 1'b1};
            end
        end else begin
            rd_word_d  = rd_word_q;
        end
    end

    // Strip RAM write port (contents need no reset)
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_addr_s] <= data_in;
        end
    end

    // Strip RAM read port: OUT_BYTES consecutive bytes, first byte in MSBs
    always_ff @(posedge clk) begin
        if (issue_s) begin
            for (int b = 0; b < OUT_BYTES; b++) begin
                mem_data_q[OW-1-8*b -: 8] <= mem_q[rd_addr_s + AW'(b)];
            end
        end
    end

    // Control state, memory-read stage and output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q           <= 2'b00;
            wr_bank_q        <= 1'b0;
            wr_cnt_q         <= {CW{1'b0}};
            w_ready_q        <= 1'b1;
            ovf_q            <= 1'b0;
            rd_bank_q        <= 1'b0;
            rd_word_q        <= {WW{1'b0}};
            rd_mb_q          <= {MBW{1'b0}};
            rd_strip_q       <= {STW{1'b0}};
            mem_vld_q        <= 1'b0;
            mem_mb_last_q    <= 1'b0;
            mem_strip_last_q <= 1'b0;
            mem_frame_last_q <= 1'b0;
            mem_bank_q       <= 1'b0;
            data_flag_q      <= 1'b0;
            data_q           <= {OW{1'b0}};
            mb_last_q        <= 1'b0;
            frame_last_q     <= 1'b0;
            out_strip_last_q <= 1'b0;
            out_bank_q       <= 1'b0;
        end else begin
            full_q     <= full_d;
            wr_bank_q  <= wr_bank_d;
            wr_cnt_q   <= wr_cnt_d;
            w_ready_q  <= w_ready_d;
            ovf_q      <= ovf_q | (data_en & full_q[wr_bank_q]);
            rd_bank_q  <= rd_bank_d;
            rd_word_q  <= rd_word_d;
            rd_mb_q    <= rd_mb_d;
            rd_strip_q <= rd_strip_d;

            if (issue_s) begin
                mem_vld_q        <= 1'b1;
                mem_mb_last_q    <= rd_mb_last_s;
                mem_strip_last_q <= rd_strip_last_s;
                mem_frame_last_q <= rd_frame_last_s;
                mem_bank_q       <= rd_bank_q;
            end else if (out_adv_s) begin
                mem_vld_q        <= 1'b0;
            end else begin
                mem_vld_q        <= mem_vld_q;
            end

            // Output only moves when empty or consumed, so stalls hold it
            if (out_adv_s) begin
                data_flag_q      <= mem_vld_q;
                mb_last_q        <= mem_vld_q & mem_mb_last_q;
                frame_last_q     <= mem_vld_q & mem_frame_last_q;
                out_strip_last_q <= mem_vld_q & mem_strip_last_q;
                out_bank_q       <= mem_bank_q;
                if (mem_vld_q) begin
                    data_q <= mem_data_q;
                end else begin
                    data_q <= data_q;
                end
            end else begin
                data_flag_q      <= data_flag_q;
            end
        end
    end

endmodule

// File: tb/tb_yuv_mb_reorder.sv
// -----------------------------------------------------------------------------
// tb_yuv_mb_reorder
//   Directed bench for yuv_mb_reorder at 32x32, 4-byte words. Each input byte
//   is its strip offset[7:0], so every output word can be derived from the
//   macroblock geometry alone.
// -----------------------------------------------------------------------------
module tb_yuv_mb_reorder;

    localparam int IMG_W  = 32;
    localparam int IMG_H  = 32;
    localparam int OB     = 4;
    localparam int STRIP  = 768;
    localparam int NMB    = 2;
    localparam int NSTRIP = 2;
`ifdef LUMA_ONLY_EN
    localparam int WPM    = 64;
`else
    localparam int WPM    = 96;
`endif
    localparam int FW     = WPM * NMB * NSTRIP;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  data_in = 8'd0;
    logic        data_en = 1'b0;
    logic        r_ready = 1'b0;
    logic        w_ready, data_flag, mb_last, frame_last, ovf;
    logic [31:0] data_o;

    int          errors = 0;
    int          checks = 0;
    int          widx = 0;
    int          cyc_a, cyc_b, cyc_c;
    logic [31:0] captured [0:511];

    yuv_mb_reorder #(.IMG_W(IMG_W), .IMG_H(IMG_H), .OUT_BYTES(OB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .data_en    (data_en),
        .w_ready    (w_ready),
        .r_ready    (r_ready),
        .data_flag  (data_flag),
        .data_o     (data_o),
        .mb_last    (mb_last),
        .frame_last (frame_last),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Expected word idx of a frame, from the macroblock layout of a strip
    function automatic logic [31:0] exp_word(input int idx);
        int w, m, o, a;
        logic [31:0] r;
        w = idx % WPM;
        m = (idx / WPM) % NMB;
        o = w * OB;
        if (o < 256)      a = (o / 16) * IMG_W + 16 * m + (o % 16);
        else if (o < 320) a = 16 * IMG_W + ((o - 256) / 8) * (IMG_W / 2) + 8 * m + (o % 8);
        else              a = 20 * IMG_W + ((o - 320) / 8) * (IMG_W / 2) + 8 * m + (o % 8);
        for (int b = 0; b < 4; b++) r[31-8*b -: 8] = 8'(a + b);
        return r;
    endfunction

    task automatic write_bytes(input int n);
        for (int i = 0; i < n; i++) begin
            data_in = 8'(i % STRIP);
            data_en = 1'b1;
            tick();
        end
        data_en = 1'b0;
    endtask

    task automatic read_words(input int n, input bit toggle, output int cycles);
        int   cnt;
        int   cyc;
        bit   stalled;
        logic [33:0] hold;
        cnt = 0;
        cyc = 0;
        hold = 34'd0;
        while (cnt < n && cyc < 2000) begin
            r_ready = toggle ? 1'(cyc % 2) : 1'b1;
            stalled = 1'b0;
            if (data_flag && r_ready) begin
                chk("word", data_o, exp_word(widx));
                chk("mb_last", mb_last, ((widx % WPM) == WPM - 1));
                chk("frame_last", frame_last, (widx == FW - 1));
                captured[widx] = data_o;
                widx = (widx + 1) % FW;
                cnt++;
            end else if (data_flag) begin
                hold = {data_o, mb_last, frame_last};
                stalled = 1'b1;
            end
            tick();
            if (stalled) chk("hold", {data_flag, data_o, mb_last, frame_last}, {1'b1, hold});
            cyc++;
        end
        r_ready = 1'b0;
        chk("rd_count", cnt, n);
        cycles = cyc;
    endtask

    task automatic chk_reset_outputs;
        chk("rst_w_ready", w_ready, 1'b1);
        chk("rst_data_flag", data_flag, 1'b0);
        chk("rst_data_o", data_o, 32'h0);
        chk("rst_mb_last", mb_last, 1'b0);
        chk("rst_frame_last", frame_last, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        chk_reset_outputs();
        rst_n = 1'b1;
        tick();

        // Fill both banks with no consumer; the third strip finds no room
        write_bytes(2 * STRIP - 1);
        chk("w_ready_before_full", w_ready, 1'b1);
        data_in = 8'hFF;
        data_en = 1'b1;
        tick();
        data_en = 1'b0;
        chk("w_ready_full", w_ready, 1'b0);
        chk("ovf_before", ovf, 1'b0);
        data_en = 1'b1;
        tick();
        data_en = 1'b0;
        tick();
        chk("ovf_set", ovf, 1'b1);
        chk("prefetch_flag", data_flag, 1'b1);
        chk("prefetch_word", data_o, 32'h00010203);

        // Full frame read continuously; strip 0 drain frees the write bank
        read_words(FW/2 - 1, 1'b0, cyc_a);
        chk("w_ready_not_drained", w_ready, 1'b0);
        read_words(1, 1'b0, cyc_b);
        chk("w_ready_drained", w_ready, 1'b1);
        read_words(FW/2, 1'b0, cyc_c);
        chk("no_bubbles", cyc_a + cyc_b + cyc_c, FW);
        chk("drained_flag", data_flag, 1'b0);
        chk("ovf_sticky", ovf, 1'b1);
        chk("mb0_w0", captured[0], 32'h00010203);
        chk("mb0_w4", captured[4], 32'h20212223);
`ifdef LUMA_ONLY_EN
        chk("mb1_w0", captured[64], 32'h10111213);
        chk("mb0_w63", captured[63], 32'hECEDEEEF);
`else
        chk("mb0_u_w64", captured[64], 32'h00010203);
        chk("mb0_u_w66", captured[66], 32'h10111213);
        chk("mb0_v_w80", captured[80], 32'h80818283);
        chk("mb1_w0", captured[96], 32'h10111213);
`endif

        // Next frame: data_flag two cycles after the filling write
        write_bytes(STRIP);
        chk("flag_lat0", data_flag, 1'b0);
        tick();
        chk("flag_lat1", data_flag, 1'b0);
        tick();
        chk("flag_lat2", data_flag, 1'b1);

        // Backpressure: r_ready toggles, same sequence, stalls hold
        read_words(FW/2, 1'b1, cyc_a);
        chk("restart_w0", captured[0], 32'h00010203);

        // Reset in the middle of the second strip
        write_bytes(STRIP);
        read_words(300 - FW/2, 1'b0, cyc_a);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        tick();
        rst_n = 1'b1;
        widx = 0;
        tick();
        chk("post_rst_flag", data_flag, 1'b0);
        write_bytes(STRIP);
        tick();
        tick();
        read_words(WPM, 1'b0, cyc_a);
        chk("post_rst_w0", captured[0], 32'h00010203);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
